// File: rtl/golden_nonce_arbiter_pkg.sv
// Shared definitions for the golden-nonce result arbiter: widths, helpers and FSM encodings.
package golden_nonce_arbiter_pkg;

    localparam int unsigned NONCE_W_DEFAULT = 32;

    localparam logic StIdle  = 1'b0;
    localparam logic StOffer = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Source index is at least one bit wide, even with a single miner.
    function automatic int unsigned src_width(input int unsigned n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/golden_nonce_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans requests starting just after the last granted index.
module rr_arbiter
    import golden_nonce_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MINERS = 4,
    localparam int unsigned SRC_W = src_width(NUM_MINERS)
) (
    input  logic                  hash_clk,
    input  logic                  reset,
    input  logic [NUM_MINERS-1:0] req,
    input  logic                  advance,
    output logic [NUM_MINERS-1:0] grant_onehot,
    output logic [SRC_W-1:0]      grant_idx,
    output logic                  any
);

    logic [SRC_W-1:0] ptr_q;
    int unsigned      scan_idx;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        scan_idx     = 0;
        for (int unsigned k = 1; k <= NUM_MINERS; k++) begin
            scan_idx = (32'(ptr_q) + k) % NUM_MINERS;
            if (!any && req[SRC_W'(scan_idx)]) begin
                any                            = 1'b1;
                grant_onehot[SRC_W'(scan_idx)] = 1'b1;
                grant_idx                      = SRC_W'(scan_idx);
            end
        end
    end

    // Pointer starts at the last index so miner 0 has first priority out of reset.
    always_ff @(posedge hash_clk) begin
        if (!reset) begin
            ptr_q <= SRC_W'(NUM_MINERS - 1);
        end else if (advance) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/golden_nonce_arbiter.sv
// Captures golden nonces from several hashers into holding slots and serialises them,
// tagged with their source, onto a single valid/ready result path.
module golden_nonce_arbiter
    import golden_nonce_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MINERS = 4,
    parameter int unsigned NONCE_W    = NONCE_W_DEFAULT,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned SRC_W     = src_width(NUM_MINERS)
) (
    input  logic                          hash_clk,
    input  logic                          reset,
    input  logic [NUM_MINERS-1:0]         found_in,
    input  logic [NUM_MINERS*NONCE_W-1:0] nonce_in,
    input  logic                          work_new,
    input  logic                          tx_ready,
    output logic                          tx_valid,
    output logic [NONCE_W-1:0]            tx_nonce,
    output logic [SRC_W-1:0]              tx_src,
    output logic [NUM_MINERS-1:0]         pending,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              stale_cnt
);

    // Wide enough to hold a counter plus the largest per-cycle increment without wrapping.
    localparam int unsigned SUM_W = CNT_W + SRC_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [NONCE_W-1:0]    slot_q [NUM_MINERS];
    logic [NONCE_W-1:0]    slot_d [NUM_MINERS];
    logic [NUM_MINERS-1:0] pending_q, pending_d;
    logic                  state_q, state_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [NONCE_W-1:0]    tx_nonce_q, tx_nonce_d;
    logic [SRC_W-1:0]      tx_src_q, tx_src_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic [CNT_W-1:0]      stale_q, stale_d;

    logic [NUM_MINERS-1:0] grant_onehot;
    logic [SRC_W-1:0]      grant_idx;
    logic                  any;
    logic                  grant_fire;
    logic [NONCE_W-1:0]    granted_nonce;
    logic [SUM_W-1:0]      drop_inc, stale_inc, drop_sum, stale_sum;

    rr_arbiter #(
        .NUM_MINERS(NUM_MINERS)
    ) u_rr_arbiter (
        .hash_clk    (hash_clk),
        .reset       (reset),
        .req         (pending_q),
        .advance     (grant_fire),
        .grant_onehot(grant_onehot),
        .grant_idx   (grant_idx),
        .any         (any)
    );

    // A flush takes precedence over issuing a new grant.
    assign grant_fire = (state_q == StIdle) && any && !work_new;

    always_comb begin
        pending_d     = pending_q;
        slot_d        = slot_q;
        state_d       = state_q;
        tx_valid_d    = tx_valid_q;
        tx_nonce_d    = tx_nonce_q;
        tx_src_d      = tx_src_q;
        drop_inc      = '0;
        stale_inc     = '0;
        granted_nonce = '0;

        for (int unsigned i = 0; i < NUM_MINERS; i++) begin
            if (grant_onehot[i]) granted_nonce = slot_q[i];
        end

        case (state_q)
            StIdle: begin
                if (grant_fire) begin
                    tx_valid_d = 1'b1;
                    tx_nonce_d = granted_nonce;
                    tx_src_d   = grant_idx;
                    state_d    = StOffer;
                    pending_d  = pending_d & ~grant_onehot;
                end
            end
            StOffer: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end else if (work_new) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                    stale_inc  = stale_inc + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        for (int unsigned i = 0; i < NUM_MINERS; i++) begin
            if (found_in[i]) begin
                if (work_new) begin
                    stale_inc = stale_inc + 1'b1;
                end else if (!pending_q[i] || (grant_fire && grant_onehot[i])) begin
                    slot_d[i]    = nonce_in[i*NONCE_W +: NONCE_W];
                    pending_d[i] = 1'b1;
                end else begin
                    drop_inc = drop_inc + 1'b1;
                end
            end
        end

        if (work_new) begin
            for (int unsigned i = 0; i < NUM_MINERS; i++) begin
                stale_inc = stale_inc + SUM_W'(pending_q[i]);
            end
            pending_d = '0;
        end

        drop_sum  = SUM_W'(drop_q) + drop_inc;
        stale_sum = SUM_W'(stale_q) + stale_inc;
        drop_d    = (drop_sum > CNT_MAX) ? '1 : drop_sum[CNT_W-1:0];
        stale_d   = (stale_sum > CNT_MAX) ? '1 : stale_sum[CNT_W-1:0];
    end

    always_ff @(posedge hash_clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_MINERS; i++) slot_q[i] <= '0;
            pending_q  <= '0;
            state_q    <= StIdle;
            tx_valid_q <= 1'b0;
            tx_nonce_q <= '0;
            tx_src_q   <= '0;
            drop_q     <= '0;
            stale_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_MINERS; i++) slot_q[i] <= slot_d[i];
            pending_q  <= pending_d;
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_nonce_q <= tx_nonce_d;
            tx_src_q   <= tx_src_d;
            drop_q     <= drop_d;
            stale_q    <= stale_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_nonce  = tx_nonce_q;
    assign tx_src    = tx_src_q;
    assign pending   = pending_q;
    assign drop_cnt  = drop_q;
    assign stale_cnt = stale_q;

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Directed bench for golden_nonce_arbiter: capture, round-robin, backpressure, flush, reset, saturation.
module tb_golden_nonce_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned NW = 32;
    localparam int unsigned CW = 4;

    logic            hash_clk = 1'b0;
    logic            reset;
    logic [NM-1:0]   found_in;
    logic [NM*NW-1:0] nonce_in;
    logic            work_new;
    logic            tx_ready;
    logic            tx_valid;
    logic [NW-1:0]   tx_nonce;
    logic [1:0]      tx_src;
    logic [NM-1:0]   pending;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   stale_cnt;

    int total = 0;
    int bad   = 0;

    golden_nonce_arbiter #(
        .NUM_MINERS(NM),
        .NONCE_W   (NW),
        .CNT_W     (CW)
    ) dut (
        .hash_clk (hash_clk),
        .reset    (reset),
        .found_in (found_in),
        .nonce_in (nonce_in),
        .work_new (work_new),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_nonce (tx_nonce),
        .tx_src   (tx_src),
        .pending  (pending),
        .drop_cnt (drop_cnt),
        .stale_cnt(stale_cnt)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic step();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_nonce(input int unsigned idx, input logic [NW-1:0] v);
        nonce_in[idx*NW +: NW] = v;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(tx_valid), 64'd0);
        check({tag, "_nonce"}, 64'(tx_nonce), 64'd0);
        check({tag, "_src"}, 64'(tx_src), 64'd0);
        check({tag, "_pending"}, 64'(pending), 64'd0);
        check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
        check({tag, "_stale"}, 64'(stale_cnt), 64'd0);
    endtask

    initial begin
        reset    = 1'b0;
        found_in = '0;
        nonce_in = '0;
        work_new = 1'b0;
        tx_ready = 1'b0;
        step();
        check_reset_values("rst0");
        reset = 1'b1;

        // Single result from miner 2
        tx_ready = 1'b1;
        found_in = 4'b0100;
        set_nonce(2, 32'hDEADBEEF);
        step();
        found_in = '0;
        check("single_pend", 64'(pending), 64'h4);
        check("single_nv", 64'(tx_valid), 64'd0);
        step();
        check("single_valid", 64'(tx_valid), 64'd1);
        check("single_nonce", 64'(tx_nonce), 64'hDEADBEEF);
        check("single_src", 64'(tx_src), 64'd2);
        check("single_pend0", 64'(pending), 64'd0);
        step();
        check("single_done", 64'(tx_valid), 64'd0);

        // Round-robin from a fresh pointer
        reset = 1'b0;
        step();
        reset = 1'b1;
        found_in = 4'b1111;
        for (int i = 0; i < 4; i++) set_nonce(i, 32'h10 + i);
        step();
        found_in = '0;
        check("rr_pend", 64'(pending), 64'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_valid", 64'(tx_valid), 64'd1);
            check("rr_src", 64'(tx_src), 64'(k));
            check("rr_nonce", 64'(tx_nonce), 64'(32'h10 + k));
            step();
            check("rr_gap", 64'(tx_valid), 64'd0);
        end
        found_in = 4'b1001;
        set_nonce(0, 32'h20);
        set_nonce(3, 32'h23);
        step();
        found_in = '0;
        step();
        check("wrap_src0", 64'(tx_src), 64'd0);
        check("wrap_nonce0", 64'(tx_nonce), 64'h20);
        step();
        check("wrap_gap", 64'(tx_valid), 64'd0);
        step();
        check("wrap_src3", 64'(tx_src), 64'd3);
        check("wrap_nonce3", 64'(tx_nonce), 64'h23);
        step();
        check("wrap_done", 64'(tx_valid), 64'd0);

        // Backpressure: miner 0 holds the output, miner 1 fills then overflows its slot
        tx_ready = 1'b0;
        found_in = 4'b0001;
        set_nonce(0, 32'h55);
        step();
        found_in = 4'b0010;
        set_nonce(1, 32'hA);
        step();
        set_nonce(1, 32'hB);
        step();
        found_in = '0;
        check("bp_drop", 64'(drop_cnt), 64'd1);
        check("bp_pend", 64'(pending), 64'h2);
        check("bp_valid", 64'(tx_valid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_valid", 64'(tx_valid), 64'd1);
            check("stall_nonce", 64'(tx_nonce), 64'h55);
            check("stall_src", 64'(tx_src), 64'd0);
        end
        tx_ready = 1'b1;
        step();
        check("bp_hs", 64'(tx_valid), 64'd0);
        step();
        check("bp_valid1", 64'(tx_valid), 64'd1);
        check("bp_src1", 64'(tx_src), 64'd1);
        check("bp_nonceA", 64'(tx_nonce), 64'hA);
        step();
        check("bp_done", 64'(tx_valid), 64'd0);
        check("bp_pend0", 64'(pending), 64'd0);
        check("bp_drop_keep", 64'(drop_cnt), 64'd1);

        // Flush while offering miner 3 with miners 0 and 2 pending and miner 1 strobing
        tx_ready = 1'b0;
        found_in = 4'b1000;
        set_nonce(3, 32'h33);
        step();
        found_in = 4'b0101;
        set_nonce(0, 32'h40);
        set_nonce(2, 32'h42);
        step();
        found_in = '0;
        check("fl_valid", 64'(tx_valid), 64'd1);
        check("fl_src", 64'(tx_src), 64'd3);
        check("fl_pend", 64'(pending), 64'h5);
        work_new = 1'b1;
        found_in = 4'b0010;
        set_nonce(1, 32'h41);
        step();
        work_new = 1'b0;
        found_in = '0;
        check("fl_stale", 64'(stale_cnt), 64'd4);
        check("fl_pend0", 64'(pending), 64'd0);
        check("fl_valid0", 64'(tx_valid), 64'd0);
        tx_ready = 1'b1;
        step();
        check("fl_quiet1", 64'(tx_valid), 64'd0);
        step();
        check("fl_quiet2", 64'(tx_valid), 64'd0);

        // Flush coinciding with a handshake, then flush beating a grant in idle
        tx_ready = 1'b0;
        found_in = 4'b0001;
        set_nonce(0, 32'h77);
        step();
        found_in = '0;
        step();
        check("fh_valid", 64'(tx_valid), 64'd1);
        check("fh_nonce", 64'(tx_nonce), 64'h77);
        tx_ready = 1'b1;
        work_new = 1'b1;
        step();
        work_new = 1'b0;
        check("fh_valid0", 64'(tx_valid), 64'd0);
        check("fh_stale", 64'(stale_cnt), 64'd4);
        found_in = 4'b0010;
        set_nonce(1, 32'h5);
        step();
        found_in = '0;
        work_new = 1'b1;
        step();
        work_new = 1'b0;
        check("fi_valid", 64'(tx_valid), 64'd0);
        check("fi_pend", 64'(pending), 64'd0);
        check("fi_stale", 64'(stale_cnt), 64'd5);
        step();
        check("fi_nogrant", 64'(tx_valid), 64'd0);

        // Reset while offering, with another slot pending
        tx_ready = 1'b0;
        found_in = 4'b0100;
        set_nonce(2, 32'h9);
        step();
        found_in = 4'b0001;
        set_nonce(0, 32'h8);
        step();
        found_in = '0;
        check("mr_valid", 64'(tx_valid), 64'd1);
        check("mr_src", 64'(tx_src), 64'd2);
        check("mr_pend", 64'(pending), 64'h1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_reset_values("rst_mid");

        // Drop counter saturation: 3 simultaneous drops, then 17 single drops
        found_in = 4'b0001;
        step();
        found_in = 4'b1110;
        step();
        step();
        found_in = '0;
        check("sat_pop", 64'(drop_cnt), 64'd3);
        check("sat_valid", 64'(tx_valid), 64'd1);
        found_in = 4'b0010;
        repeat (11) step();
        check("sat_14", 64'(drop_cnt), 64'hE);
        repeat (6) step();
        found_in = '0;
        check("sat_hold", 64'(drop_cnt), 64'hF);
        check("sat_stale", 64'(stale_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
